// File: rtl/ser_feeder_pkg.sv
// Shared definitions for the serial bit feeder: FSM encodings, default width, counter sizing.
package ser_feeder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_PAR   = 2'd2;
    localparam state_t ST_GAP   = 2'd3;

    localparam int unsigned DEF_W  = 8;
    localparam int unsigned GCNT_W = 4;

    // Bits needed to count 0..n.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Up-counter with synchronous clear, increment, and a terminal-count flag; saturates at MAX.
module ser_bit_counter
    import ser_feeder_pkg::*;
#(
    parameter int unsigned CW  = GCNT_W,
    parameter int unsigned MAX = 1
) (
    input  logic ck,
    input  logic rs,
    input  logic clr,
    input  logic inc,
    output logic tc_c
);

    logic [CW-1:0] cnt;

    assign tc_c = (cnt == CW'(MAX));

    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !tc_c) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ser_bit_feeder.sv
// Buffers one parallel word and shifts words out MSB-first on s, with optional idle gap between words.
// Optional even-parity bit after each word is enabled by defining SER_PARITY_EN.
module ser_bit_feeder
    import ser_feeder_pkg::*;
#(
    parameter int unsigned W        = DEF_W,
    parameter int unsigned GAP      = 0,
    parameter logic        IDLE_LVL = 1'b0
) (
    input  logic         ck,
    input  logic         rs,
    input  logic [W-1:0] din,
    input  logic         din_vld,
    output logic         din_rdy,
    output logic         s,
    output logic         s_vld,
    output logic         last,
    output logic         busy
);

    localparam int unsigned CW   = cnt_w(W);
    localparam int unsigned GMAX = (GAP > 0) ? GAP - 1 : 0;

    state_t       state, nxt, end_st;
    logic [W-1:0] hld;
    logic [W-2:0] sr;
    logic         hld_full, fin;
    logic         accept_c, load_c, hld_full_c;
    logic         cnt_tc_c, gcnt_tc_c;
    logic         s_d, s_vld_d, last_d, fin_d;
`ifdef SER_PARITY_EN
    logic         par;
`endif

    assign accept_c   = din_vld && din_rdy;
    // sr is (re)loaded on every entry into SHIFT, including word-to-word without leaving SHIFT
    assign load_c     = (nxt == ST_SHIFT) && ((state != ST_SHIFT) || fin);
    assign hld_full_c = accept_c || (hld_full && !load_c);

    // cnt tracks the bit index on s; terminal one before the last bit so last can be registered
    ser_bit_counter #(.CW(CW), .MAX(W - 2)) u_cnt (
        .ck   (ck),
        .rs   (rs),
        .clr  (load_c),
        .inc  (state == ST_SHIFT),
        .tc_c (cnt_tc_c)
    );

    ser_bit_counter #(.CW(GCNT_W), .MAX(GMAX)) u_gcnt (
        .ck   (ck),
        .rs   (rs),
        .clr  ((nxt == ST_GAP) && (state != ST_GAP)),
        .inc  (state == ST_GAP),
        .tc_c (gcnt_tc_c)
    );

    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            state <= ST_IDLE;
        end else begin
            state <= nxt;
        end
    end

    always_comb begin
        nxt    = state;
        end_st = (GAP > 0) ? ST_GAP : (hld_full ? ST_SHIFT : ST_IDLE);
        case (state)
            ST_IDLE:  if (hld_full) nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (fin) begin
`ifdef SER_PARITY_EN
                    nxt = ST_PAR;
`else
                    nxt = end_st;
`endif
                end
            end
`ifdef SER_PARITY_EN
            ST_PAR:   nxt = end_st;
`endif
            ST_GAP:   if (gcnt_tc_c) nxt = hld_full ? ST_SHIFT : ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // Output values for the cycle after this edge, derived from the state being entered
    always_comb begin
        s_d     = IDLE_LVL;
        s_vld_d = 1'b0;
        last_d  = 1'b0;
        fin_d   = 1'b0;
        case (nxt)
            ST_SHIFT: begin
                s_vld_d = 1'b1;
                s_d     = load_c ? hld[W-1] : sr[W-2];
                fin_d   = !load_c && cnt_tc_c;
`ifndef SER_PARITY_EN
                last_d  = fin_d;
`endif
            end
`ifdef SER_PARITY_EN
            ST_PAR: begin
                s_vld_d = 1'b1;
                s_d     = par;
                last_d  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            hld      <= '0;
            hld_full <= 1'b0;
            din_rdy  <= 1'b1;
            sr       <= '0;
            fin      <= 1'b0;
            s        <= IDLE_LVL;
            s_vld    <= 1'b0;
            last     <= 1'b0;
            busy     <= 1'b0;
`ifdef SER_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            if (accept_c) hld <= din;
            hld_full <= hld_full_c;
            din_rdy  <= !hld_full_c;
            if (load_c) begin
                sr <= hld[W-2:0];
            end else if (state == ST_SHIFT) begin
                sr <= sr << 1;
            end
`ifdef SER_PARITY_EN
            if (load_c) par <= ^hld;
`endif
            fin   <= fin_d;
            s     <= s_d;
            s_vld <= s_vld_d;
            last  <= last_d;
            busy  <= (nxt != ST_IDLE) || hld_full_c;
        end
    end

endmodule

// File: tb/tb_ser_bit_feeder.sv
// Randomized and directed bench for ser_bit_feeder; two instances (GAP=0 and GAP=2) against a schedule model.
module tb_ser_bit_feeder;

    localparam int unsigned W = 8;
`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       ck = 1'b0;
    logic       rs = 1'b1;
    logic [7:0] din     [2];
    logic       din_vld [2];
    logic       din_rdy [2];
    logic       s       [2];
    logic       s_vld   [2];
    logic       last    [2];
    logic       busy    [2];

    ser_bit_feeder #(.W(W), .GAP(0), .IDLE_LVL(1'b0)) u_dut0 (
        .ck(ck), .rs(rs), .din(din[0]), .din_vld(din_vld[0]), .din_rdy(din_rdy[0]),
        .s(s[0]), .s_vld(s_vld[0]), .last(last[0]), .busy(busy[0])
    );

    ser_bit_feeder #(.W(W), .GAP(2), .IDLE_LVL(1'b0)) u_dut1 (
        .ck(ck), .rs(rs), .din(din[1]), .din_vld(din_vld[1]), .din_rdy(din_rdy[1]),
        .s(s[1]), .s_vld(s_vld[1]), .last(last[1]), .busy(busy[1])
    );

    always #5 ck = ~ck;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Schedule model: each word gets a load edge L; its bits occupy the NB cycles after edges L..L+NB-1,
    // and the next load may happen no earlier than edge L+NB+GAP.
    int         gapv [2] = '{0, 2};
    int         cyc = 0;
    logic       m_hf [2];
    logic [7:0] m_hld [2];
    logic [7:0] m_cur [2];
    bit         m_have [2];
    int         m_L [2];
    int         m_E [2];
    logic       m_s [2], m_vld [2], m_last [2], m_busy [2], m_rdy [2];

    function automatic logic bit_of(input logic [7:0] w, input int k);
        logic [7:0] v;
        v = w;
        if (k < 8) return v[7-k];
        return ^v;
    endfunction

    always @(posedge ck) begin
        bit acc;
        int k;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rs) begin
                m_hf[i] = 1'b0; m_have[i] = 1'b0; m_E[i] = 0; m_L[i] = 0;
                m_s[i] = 1'b0; m_vld[i] = 1'b0; m_last[i] = 1'b0; m_busy[i] = 1'b0; m_rdy[i] = 1'b1;
            end else begin
                acc = din_vld[i] && !m_hf[i];
                if (m_hf[i] && cyc >= m_E[i]) begin
                    m_cur[i]  = m_hld[i];
                    m_L[i]    = cyc;
                    m_have[i] = 1'b1;
                    m_E[i]    = cyc + NB + gapv[i];
                    m_hf[i]   = 1'b0;
                end
                if (acc) begin
                    m_hld[i] = din[i];
                    m_hf[i]  = 1'b1;
                end
                k = cyc - m_L[i];
                if (m_have[i] && k < NB) begin
                    m_vld[i]  = 1'b1;
                    m_s[i]    = bit_of(m_cur[i], k);
                    m_last[i] = (k == NB - 1);
                end else begin
                    m_vld[i] = 1'b0; m_s[i] = 1'b0; m_last[i] = 1'b0;
                end
                m_busy[i] = m_hf[i] || (m_have[i] && cyc < m_E[i]);
                m_rdy[i]  = !m_hf[i];
            end
        end
    end

    always @(negedge ck) begin
        if (!rs) begin
            for (int i = 0; i < 2; i++) begin
                chk("s",       i, 32'(s[i]),       32'(m_s[i]));
                chk("s_vld",   i, 32'(s_vld[i]),   32'(m_vld[i]));
                chk("last",    i, 32'(last[i]),    32'(m_last[i]));
                chk("busy",    i, 32'(busy[i]),    32'(m_busy[i]));
                chk("din_rdy", i, 32'(din_rdy[i]), 32'(m_rdy[i]));
            end
        end
    end

    // Stream recorder for directed checks
    bit          rec_clr = 1'b0;
    int          rec_n [2], run [2], max_run [2], zrun [2], last_gap [2], last_pos [2];
    logic [31:0] rec_bits [2];
    bit          seen [2];

    always @(negedge ck) begin
        for (int i = 0; i < 2; i++) begin
            if (rec_clr) begin
                rec_n[i] = 0; run[i] = 0; max_run[i] = 0; zrun[i] = 0;
                last_gap[i] = -1; last_pos[i] = 0; rec_bits[i] = '0; seen[i] = 1'b0;
            end else if (!rs) begin
                if (s_vld[i]) begin
                    rec_bits[i] = {rec_bits[i][30:0], s[i]};
                    rec_n[i]++;
                    if (seen[i] && zrun[i] > 0) last_gap[i] = zrun[i];
                    zrun[i] = 0;
                    run[i]++;
                    if (run[i] > max_run[i]) max_run[i] = run[i];
                    seen[i] = 1'b1;
                    if (last[i]) last_pos[i] = rec_n[i];
                end else begin
                    run[i] = 0;
                    if (seen[i]) zrun[i]++;
                end
            end
        end
    end

    task automatic clear_rec();
        rec_clr = 1'b1;
        @(posedge ck); #1;
        rec_clr = 1'b0;
    endtask

    task automatic push(input int i, input logic [7:0] w);
        bit got;
        got = 1'b0;
        din[i] = w;
        din_vld[i] = 1'b1;
        for (int lim = 0; lim < 100 && !got; lim++) begin
            @(negedge ck);
            got = din_rdy[i];
            @(posedge ck); #1;
        end
        din_vld[i] = 1'b0;
        if (!got) chk("push_timeout", i, 32'(got), 32'd1);
    endtask

    task automatic wait_idle(input int i);
        int lim;
        lim = 0;
        do begin
            @(negedge ck);
            lim++;
        end while (busy[i] && lim < 300);
        if (busy[i]) chk("idle_timeout", i, 32'(busy[i]), 32'd0);
        @(posedge ck); #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_s"},       i, 32'(s[i]),       32'd0);
            chk({tag, "_s_vld"},   i, 32'(s_vld[i]),   32'd0);
            chk({tag, "_last"},    i, 32'(last[i]),    32'd0);
            chk({tag, "_busy"},    i, 32'(busy[i]),    32'd0);
            chk({tag, "_din_rdy"}, i, 32'(din_rdy[i]), 32'd1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int thr;
        for (int i = 0; i < 2; i++) begin
            din[i] = '0;
            din_vld[i] = 1'b0;
        end
        rs = 1'b1;
        repeat (3) @(posedge ck);
        #1 rs = 1'b0;
        @(negedge ck);
        chk_reset_outputs("rst");
        @(posedge ck); #1;

        // Single word on both instances
        clear_rec();
        fork
            push(0, 8'hAC);
            push(1, 8'hAC);
        join
        wait_idle(0);
        wait_idle(1);
        repeat (3) @(posedge ck);
        #1;
`ifdef SER_PARITY_EN
        chk("single_bits", 0, 32'(rec_bits[0][8:1]), 32'h0000_00AC);
        chk("single_par",  0, 32'(rec_bits[0][0]),   32'd0);
`else
        chk("single_bits", 0, 32'(rec_bits[0][7:0]), 32'h0000_00AC);
`endif
        chk("single_cnt",  0, 32'(rec_n[0]),    32'(NB));
        chk("single_last", 0, 32'(last_pos[0]), 32'(NB));
        chk("single_busy", 0, 32'(busy[0]),     32'd0);

        // Back-to-back words with valid held
        clear_rec();
        fork
            begin push(0, 8'hAC); push(0, 8'h35); end
            begin push(1, 8'hAC); push(1, 8'h35); end
        join
        wait_idle(0);
        wait_idle(1);
        chk("b2b_run",  0, 32'(max_run[0]),  32'(2 * NB));
        chk("b2b_cnt",  0, 32'(rec_n[0]),    32'(2 * NB));
        chk("gap_len",  1, 32'(last_gap[1]), 32'd2);
        chk("gap_run",  1, 32'(max_run[1]),  32'(NB));
`ifndef SER_PARITY_EN
        chk("b2b_bits", 0, 32'(rec_bits[0][15:0]), 32'h0000_AC35);
`endif

        // Asynchronous reset after the third bit with a second word held
        clear_rec();
        push(0, 8'hAC);
        push(0, 8'h35);
        for (int lim = 0; lim < 50 && rec_n[0] < 3; lim++) begin
            @(negedge ck); #1;
        end
        chk("pre_reset_bits", 0, 32'(rec_n[0]), 32'd3);
        #1 rs = 1'b1;
        #1;
        chk_reset_outputs("async");
        @(posedge ck);
        @(posedge ck); #1;
        rs = 1'b0;
        clear_rec();
        repeat (20) @(posedge ck);
        #1;
        chk("post_reset_bits", 0, 32'(rec_n[0]), 32'd0);
        chk("post_reset_busy", 0, 32'(busy[0]),  32'd0);

`ifdef SER_PARITY_EN
        clear_rec();
        push(0, 8'h07);
        wait_idle(0);
        chk("par07_bits", 0, 32'(rec_bits[0][8:0]), 32'h0000_000F);
        chk("par07_last", 0, 32'(last_pos[0]),      32'd9);
`endif

        // Randomized traffic in phases of differing offered load
        for (int c = 0; c < 2000; c++) begin
            case ((c / 250) % 4)
                0: thr = 90;
                1: thr = 50;
                2: thr = 15;
                default: thr = 100;
            endcase
            for (int i = 0; i < 2; i++) begin
                din_vld[i] = ($urandom % 100) < thr;
                din[i] = 8'($urandom);
            end
            @(posedge ck); #1;
        end
        for (int i = 0; i < 2; i++) din_vld[i] = 1'b0;
        repeat (60) @(posedge ck);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
